// File: rtl/aes256_pkg.sv
// Shared AES byte/block types and the byte-assembly state encoding,
// common to the 1-to-16 input register and the 16-to-1 output register.
package aes256_pkg;

   localparam int NB_BYTES = 16;

   typedef logic [7:0] byte_t;
   typedef byte_t [NB_BYTES-1:0] block_t;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } asm_state_t;

endpackage : aes256_pkg

// File: rtl/mod_reg16_1to16.sv
// Byte-serial to 16-byte block assembly register: byte k of a block lands in
// lane k, and the completed block is held on o until rd_ack releases it.
module mod_reg16_1to16
   import aes256_pkg::*;
#(
   parameter int N = NB_BYTES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [7:0]            i,
   output logic                  wr_ready,
   input  logic                  flush,
   input  logic                  rd_ack,
   output logic [N-1:0][7:0]     o,
   output logic                  reg_full,
   output logic [$clog2(N):0]    count
);

   localparam int CW    = $clog2(N);
   localparam int CNT_W = CW + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

   asm_state_t             state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [N-1:0]           lane_we;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lane_we = '0;
      case (state_q)
         FILL: begin
            if (flush) begin
               count_d = '0;
            end else if (wr_en) begin
               lane_we[count_q[CW-1:0]] = 1'b1;
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_IDX) begin
                  state_d = FULL;
               end
            end
         end
         FULL: begin
            // A byte arriving on the ack edge opens the next block at lane 0.
            if (rd_ack) begin
               state_d = FILL;
               if (wr_en) begin
                  lane_we[0] = 1'b1;
                  count_d    = CNT_W'(1);
               end else begin
                  count_d = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [7:0] lane_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            lane_q <= '0;
         end else if (lane_we[gi]) begin
            lane_q <= i;
         end
      end

      assign o[gi] = lane_q;
   end

   assign reg_full = (state_q == FULL);
   assign count    = count_q;
   assign wr_ready = (state_q != FULL) || rd_ack;

endmodule : mod_reg16_1to16

// File: tb/tb_mod_reg16_1to16.sv
// Directed bench for the byte-to-block assembly register; completed blocks are
// queued by the stimulus and popped when reg_full appears.
module tb_mod_reg16_1to16;
   import aes256_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [7:0]  i;
   logic        wr_ready;
   logic        flush;
   logic        rd_ack;
   block_t      o;
   logic        reg_full;
   logic [4:0]  count;

   int checks   = 0;
   int failures = 0;

   block_t exp_blk;
   int     exp_cnt;
   block_t sb_q[$];
   block_t exp_pop;

   always #5 clk = ~clk;

   mod_reg16_1to16 #(.N(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .i        (i),
      .wr_ready (wr_ready),
      .flush    (flush),
      .rd_ack   (rd_ack),
      .o        (o),
      .reg_full (reg_full),
      .count    (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_o"}, o, '0);
      chk({tag, "_full"}, 128'(reg_full), 128'd0);
      chk({tag, "_count"}, 128'(count), 128'd0);
      chk({tag, "_ready"}, 128'(wr_ready), 128'd1);
   endtask

   // Drive one byte, update the lane model, and retire a block when complete.
   task automatic put_byte(input logic [7:0] b);
      wr_en = 1'b1;
      i     = b;
      tick();
      wr_en = 1'b0;
      exp_blk[exp_cnt] = b;
      exp_cnt++;
      if (exp_cnt == 16) sb_q.push_back(exp_blk);
      $display("byte  lane=%0d data=%h count=%0d reg_full=%0b", exp_cnt - 1, b, count, reg_full);
      chk("count", 128'(count), 128'(exp_cnt));
      if (exp_cnt == 16) begin
         chk("full_rise", 128'(reg_full), 128'd1);
         if (sb_q.size() == 0) begin
            chk("sb_empty", 128'd0, 128'd1);
         end else begin
            exp_pop = sb_q.pop_front();
            chk("block", o, exp_pop);
            $display("block o=%h", o);
         end
      end else begin
         chk("not_full", 128'(reg_full), 128'd0);
      end
   endtask

   task automatic put_block(input logic [7:0] base, input logic [7:0] step);
      for (int k = 0; k < 16; k++) put_byte(8'(base + 8'(k) * step));
   endtask

   task automatic ack();
      rd_ack = 1'b1;
      #1;
      chk("ack_ready", 128'(wr_ready), 128'd1);
      tick();
      rd_ack  = 1'b0;
      exp_cnt = 0;
      $display("ack   count=%0d reg_full=%0b", count, reg_full);
      chk("ack_full", 128'(reg_full), 128'd0);
      chk("ack_count", 128'(count), 128'd0);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      exp_blk = '0;
      exp_cnt = 0;
      $display("reset %s count=%0d reg_full=%0b", tag, count, reg_full);
      chk_reset_state(tag);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; i = '0; flush = 1'b0; rd_ack = 1'b0;
      exp_blk = '0; exp_cnt = 0;
      tick();
      tick();
      reset = 1'b0;
      chk_reset_state("por");

      // Block 0x00..0x0F, then a write while full is dropped.
      put_block(8'h00, 8'h01);
      wr_en = 1'b1; i = 8'hAA;
      #1;
      chk("full_ready", 128'(wr_ready), 128'd0);
      tick();
      wr_en = 1'b0;
      $display("drop  data=aa count=%0d reg_full=%0b", count, reg_full);
      chk("drop_o", o, exp_blk);
      chk("drop_count", 128'(count), 128'd16);
      chk("drop_full", 128'(reg_full), 128'd1);
      ack();

      // Even block held for five cycles before the ack.
      put_block(8'h00, 8'h02);
      for (int h = 0; h < 5; h++) begin
         tick();
         $display("hold  cycle=%0d reg_full=%0b", h, reg_full);
         chk("hold_full", 128'(reg_full), 128'd1);
         chk("hold_o", o, exp_blk);
      end
      ack();

      // Back-to-back: ack and a new byte on the same edge.
      put_block(8'h00, 8'h01);
      rd_ack = 1'b1; wr_en = 1'b1; i = 8'h40;
      #1;
      chk("b2b_ready", 128'(wr_ready), 128'd1);
      tick();
      rd_ack = 1'b0; wr_en = 1'b0;
      exp_blk[0] = 8'h40;
      exp_cnt    = 1;
      $display("b2b   data=40 count=%0d reg_full=%0b", count, reg_full);
      chk("b2b_count", 128'(count), 128'd1);
      chk("b2b_full", 128'(reg_full), 128'd0);
      chk("b2b_o", o, exp_blk);
      for (int k = 1; k < 16; k++) put_byte(8'(8'h40 + 8'(k) * 8'h04));
      chk("b2b_lane15", 128'(o[15]), 128'h7C);
      ack();

      // Flush with a simultaneous write drops the byte and restarts at lane 0.
      for (int k = 0; k < 7; k++) put_byte(8'(8'hC0 + k));
      flush = 1'b1; wr_en = 1'b1; i = 8'h55;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      exp_cnt = 0;
      $display("flush count=%0d", count);
      chk("flush_count", 128'(count), 128'd0);
      chk("flush_o", o, exp_blk);
      put_block(8'h10, 8'h01);
      chk("flush_lane0", 128'(o[0]), 128'h10);
      ack();

      // Reset mid-block and while full.
      for (int k = 0; k < 9; k++) put_byte(8'(8'h90 + k));
      do_reset("rst_mid");
      put_block(8'hE0, 8'h01);
      do_reset("rst_full");

      // rd_ack while filling is ignored.
      for (int k = 0; k < 3; k++) put_byte(8'(8'h30 + k));
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      $display("ign   count=%0d reg_full=%0b", count, reg_full);
      chk("fill_ack_count", 128'(count), 128'd3);
      chk("fill_ack_full", 128'(reg_full), 128'd0);
      chk("fill_ack_o", o, exp_blk);

      chk("sb_drained", 128'(sb_q.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mod_reg16_1to16
